// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, ASCII ALU op codes, FSM encoding and op-decode helpers
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_RLC = 4'd8;
    localparam logic [3:0] OP_RRC = 4'd9;

    // ASCII strings as seen by the ALU; NOP matches nothing so the ALU holds its output
    localparam logic [24:0] ALU_NOP = 25'h0000000;
    localparam logic [24:0] ALU_ADD = 25'h000002B;
    localparam logic [24:0] ALU_AND = 25'h0000026;
    localparam logic [24:0] ALU_OR  = 25'h000007C;
    localparam logic [24:0] ALU_XOR = 25'h000005E;
    localparam logic [24:0] ALU_NOT = 25'h000007E;
    localparam logic [24:0] ALU_RLC = 25'h0524C43;
    localparam logic [24:0] ALU_RRC = 25'h0525243;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_RRC;
    endfunction

    function automatic logic op_is_logic(input logic [3:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_XOR) || (op == OP_NOT);
    endfunction

    function automatic logic [24:0] op_ascii(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: return ALU_ADD;
            OP_AND:                         return ALU_AND;
            OP_OR:                          return ALU_OR;
            OP_XOR:                         return ALU_XOR;
            OP_NOT:                         return ALU_NOT;
            OP_RLC:                         return ALU_RLC;
            OP_RRC:                         return ALU_RRC;
            default:                        return ALU_NOP;
        endcase
    endfunction

    // Carry fed into the first slot; SUB and INC are both "+1" on top of the addend
    function automatic logic first_carry(input logic [3:0] op, input logic cin);
        case (op)
            OP_ADD, OP_RLC, OP_RRC: return cin;
            OP_SUB, OP_INC:         return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_chain_ctrl.sv
// rtl/alu_chain_ctrl.sv - sequences a WIDTH-bit operation through a 4-bit ALU one nibble per slot
module alu_chain_ctrl
    import alu_pkg::*;
#(
    parameter int WORDS   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [4*WORDS-1:0]   cmd_a,
    input  logic [4*WORDS-1:0]   cmd_b,
    input  logic                 cmd_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*WORDS-1:0]   rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic [3:0]           alu_in1,
    output logic [3:0]           alu_in2,
    output logic                 alu_c_in,
    output logic [24:0]          alu_op,
    input  logic [3:0]           alu_out,
    input  logic                 alu_c_out
);

    localparam int WIDTH  = 4 * WORDS;
    localparam int SLOT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SUB_W  = $clog2(ALU_LAT + 1);

    state_t              state_q, state_d;
    logic [3:0]          op_q;
    logic [WIDTH-1:0]    a_q, b_q, acc_q, acc_next;
    logic                carry_q, carry_next;
    logic [SLOT_W-1:0]   slot_q, nib;
    logic [SUB_W-1:0]    sub_q;
    logic [SLOT_W+1:0]   bit_base;
    logic [3:0]          a_nib, b_nib;
    logic                accept, slot_done, last_slot;

    assign accept    = cmd_valid && (state_q == ST_IDLE);
    assign slot_done = (state_q == ST_RUN) && (sub_q == SUB_W'(ALU_LAT));
    assign last_slot = (slot_q == SLOT_W'(WORDS - 1));

    // RRC walks MSB first so each nibble's shifted-out bit lands in the next lower nibble
    assign nib      = (op_q == OP_RRC) ? SLOT_W'(WORDS - 1) - slot_q : slot_q;
    assign bit_base = {nib, 2'b00};
    assign a_nib    = a_q[bit_base +: 4];
    assign b_nib    = b_q[bit_base +: 4];

    assign carry_next = op_is_logic(op_q) ? 1'b0 : alu_c_out;

    always_comb begin
        acc_next = acc_q;
        acc_next[bit_base +: 4] = alu_out;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_op    = ALU_NOP;
        alu_in1   = 4'h0;
        alu_in2   = 4'h0;
        alu_c_in  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = op_is_legal(cmd_op) ? ST_RUN : ST_RESP;
                end
            end
            ST_RUN: begin
                alu_op   = op_ascii(op_q);
                alu_in1  = a_nib;
                alu_c_in = op_is_logic(op_q) ? 1'b0 : carry_q;
                case (op_q)
                    OP_ADD, OP_AND, OP_OR, OP_XOR: alu_in2 = b_nib;
                    OP_SUB:                        alu_in2 = ~b_nib;
                    OP_DEC:                        alu_in2 = 4'hF;
                    default:                       alu_in2 = 4'h0;
                endcase
                if (slot_done && last_slot) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= 4'h0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            slot_q    <= '0;
            sub_q     <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            op_q    <= cmd_op;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            carry_q <= first_carry(cmd_op, cmd_cin);
            slot_q  <= '0;
            sub_q   <= '0;
            if (!op_is_legal(cmd_op)) begin
                rsp_data  <= '0;
                rsp_carry <= 1'b0;
                rsp_zero  <= 1'b1;
                rsp_err   <= 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            if (slot_done) begin
                sub_q   <= '0;
                acc_q   <= acc_next;
                carry_q <= carry_next;
                if (last_slot) begin
                    slot_q    <= '0;
                    rsp_data  <= acc_next;
                    rsp_carry <= carry_next;
                    rsp_zero  <= (acc_next == '0);
                    rsp_err   <= 1'b0;
                end else begin
                    slot_q <= slot_q + SLOT_W'(1);
                end
            end else begin
                sub_q <= sub_q + SUB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_chain_ctrl.sv
// tb/tb_alu_chain_ctrl.sv - directed vector bench for alu_chain_ctrl with a behavioural 4-bit ALU
module tb_alu_chain_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_cin;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a, cmd_b;
    logic        rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err;
    logic [15:0] rsp_data;
    logic [3:0]  alu_in1, alu_in2;
    logic        alu_c_in;
    logic [24:0] alu_op;
    logic [3:0]  alu_out = 4'h0;
    logic        alu_c_out = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [3:0] in1_seen [4];
    logic       op_seen;

    localparam logic [24:0] T_ADD = 25'h000002B;
    localparam logic [24:0] T_AND = 25'h0000026;
    localparam logic [24:0] T_OR  = 25'h000007C;
    localparam logic [24:0] T_XOR = 25'h000005E;
    localparam logic [24:0] T_NOT = 25'h000007E;
    localparam logic [24:0] T_RLC = 25'h0524C43;
    localparam logic [24:0] T_RRC = 25'h0525243;

    always #5 clk = ~clk;

    alu_chain_ctrl #(.WORDS(4), .ALU_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_c_in(alu_c_in), .alu_op(alu_op),
        .alu_out(alu_out), .alu_c_out(alu_c_out)
    );

    // One-cycle-latency ALU; unmatched codes hold the previous result
    always @(posedge clk) begin
        case (alu_op)
            T_ADD: {alu_c_out, alu_out} <= {1'b0, alu_in1} + {1'b0, alu_in2} + {4'b0, alu_c_in};
            T_AND: alu_out <= alu_in1 & alu_in2;
            T_OR:  alu_out <= alu_in1 | alu_in2;
            T_XOR: alu_out <= alu_in1 ^ alu_in2;
            T_NOT: alu_out <= ~alu_in1;
            T_RLC: {alu_c_out, alu_out} <= {alu_in1, alu_c_in};
            T_RRC: {alu_out, alu_c_out} <= {alu_c_in, alu_in1};
            default: ;
        endcase
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_data;
        logic        exp_carry;
        logic        exp_zero;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_cin   = cin;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a     = 16'hDEAD;
        cmd_b     = 16'hBEEF;
        cmd_cin   = ~cin;
    endtask

    task automatic wait_valid(output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        op_seen = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk);
            if (alu_op != 25'h0) op_seen = 1'b1;
            if ((n % 2) == 1 && n <= 7) in1_seen[(n - 1) / 2] = alu_in1;
            if (rsp_valid) begin
                got = 1'b1;
                lat = n;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        chk($sformatf("v%0d_cmd_ready_idle", idx), {31'b0, cmd_ready}, 1);
        issue(v.op, v.a, v.b, v.cin);
        wait_valid(lat);
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_data", idx), {16'b0, rsp_data}, {16'b0, v.exp_data});
        chk($sformatf("v%0d_carry", idx), {31'b0, rsp_carry}, {31'b0, v.exp_carry});
        chk($sformatf("v%0d_zero", idx), {31'b0, rsp_zero}, {31'b0, v.exp_zero});
        chk($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
        if (v.exp_err) chk($sformatf("v%0d_alu_quiet", idx), {31'b0, op_seen}, 0);
        if (v.op == 4'd9) begin
            chk($sformatf("v%0d_rrc_in1_seq", idx),
                {16'b0, in1_seen[0], in1_seen[1], in1_seen[2], in1_seen[3]}, 32'h0001);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_back_idle", idx), {30'b0, cmd_ready, rsp_valid}, 32'h2);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{4'd0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 9};
        vecs[1]  = '{4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9};
        vecs[2]  = '{4'd1, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b1, 1'b0, 1'b0, 9};
        vecs[3]  = '{4'd1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9};
        vecs[4]  = '{4'd8, 16'h8001, 16'h5555, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 9};
        vecs[5]  = '{4'd9, 16'h0001, 16'hAAAA, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 9};
        vecs[6]  = '{4'd2, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 9};
        vecs[7]  = '{4'd3, 16'h1000, 16'h1234, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0, 9};
        vecs[8]  = '{4'd4, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 1'b0, 1'b0, 1'b0, 9};
        vecs[9]  = '{4'd5, 16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 9};
        vecs[10] = '{4'd6, 16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 9};
        vecs[11] = '{4'd7, 16'h00FF, 16'h1234, 1'b1, 16'hFF00, 1'b0, 1'b0, 1'b0, 9};
        vecs[12] = '{4'd0, 16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0, 9};
        vecs[13] = '{4'd1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 9};
        vecs[14] = '{4'd8, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 9};
        vecs[15] = '{4'hC, 16'h1234, 16'h5678, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 16'h0;
        cmd_b     = 16'h0;
        cmd_cin   = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("reset_rsp_flags", {28'b0, rsp_valid, rsp_carry, rsp_zero, rsp_err}, 0);
        chk("reset_rsp_data", {16'b0, rsp_data}, 0);
        chk("reset_alu_op", {7'b0, alu_op}, 0);
        chk("reset_alu_ins", {23'b0, alu_in1, alu_in2, alu_c_in}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Backpressure: response must hold while a new command is offered
        issue(4'd0, 16'h0001, 16'h0002, 1'b0);
        wait_valid(lat);
        chk("bp_latency", lat, 9);
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i),
                {13'b0, rsp_valid, cmd_ready, rsp_carry, rsp_data}, {13'b0, 3'b100, 16'h0003});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_released", {30'b0, cmd_ready, rsp_valid}, 32'h2);

        // Reset during slot 2 of an ADD
        issue(4'd0, 16'h1111, 16'h2222, 1'b0);
        repeat (5) @(negedge clk);
        chk("rst_mid_running", {7'b0, alu_op}, {7'b0, T_ADD});
        chk("rst_mid_slot2_in1", {28'b0, alu_in1}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_cmd_ready", {31'b0, cmd_ready}, 1);
        chk("rst_mid_rsp", {12'b0, rsp_valid, rsp_carry, rsp_zero, rsp_err, rsp_data}, 0);
        chk("rst_mid_alu", {31'b0, alu_op == 25'h0 && alu_in1 == 4'h0 && alu_in2 == 4'h0 && !alu_c_in}, 1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst_no_rsp", seen, 0);
        run_vec('{4'd0, 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b0, 9}, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_chain_ctrl.md
Name: alu_chain_ctrl

Overview:
- Command-side initiator for the 4-bit `ALU`.
- Accepts one WIDTH-bit operation per valid/ready handshake.
- Splits the operation into nibble slots and drives the `ALU` port set (in1, in2, c_in, ASCII op) one slot at a time, chaining `c_out` into the next slot's `c_in`.
- Reassembles the result and returns it on a valid/ready response channel.
- Sits between the datapath controller and the `ALU` instance; the two are siblings in the enclosing top.

Parameters:
- WORDS, 4, number of 4-bit nibbles per operand; WIDTH = 4*WORDS.
- ALU_LAT, 1, clocks from driving the `ALU` inputs to a valid out/c_out; must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  4  opcode: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 RLC, 9 RRC; any other value is illegal.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B; ignored for INC, DEC, NOT, RLC and RRC.
- cmd_cin  in  1  carry-in for ADD, RLC and RRC.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  WIDTH  result.
- rsp_carry  out  1  final carry; 0 for logic ops.
- rsp_zero  out  1  asserted when rsp_data == 0.
- rsp_err  out  1  illegal opcode.
- alu_in1  out  4  to `ALU` in1.
- alu_in2  out  4  to `ALU` in2.
- alu_c_in  out  1  to `ALU` c_in.
- alu_op  out  25  ASCII op string ([8*3:0]) to the `ALU`.
- alu_out  in  4  from `ALU` out.
- alu_c_out  in  1  from `ALU` c_out.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; cmd_ready=1.
  - rsp_valid=0; rsp_data, rsp_carry, rsp_zero and rsp_err all 0.
  - alu_in1, alu_in2 and alu_c_in = 0; alu_op = 0, an unmatched code, so the `ALU` holds its output.
  - An in-flight command is discarded and no response is produced.
- State machine: IDLE -> RUN -> RESP -> IDLE.
- IDLE:
  - On cmd_valid & cmd_ready, latch op, A, B and cin.
  - Illegal opcode: go straight to RESP with rsp_err=1, rsp_data=0, rsp_carry=0, rsp_zero=1. rsp_valid is high in the next cycle and no `ALU` activity occurs.
- RUN:
  - WORDS slots, each ALU_LAT+1 cycles long. Operands are held stable for the whole slot.
  - alu_out and alu_c_out are sampled in the last cycle of the slot.
  - The slot counter and the sub-cycle counter both wrap to 0 on leaving RUN.
- Nibble order: LSB first for all ops except RRC, which runs MSB first.
- Op mapping; only "+", "&", "|", "^", "~", "RLC" and "RRC" are ever driven:
  - ADD: "+", in2 = B nibble, first c_in = cmd_cin.
  - SUB: "+", in2 = ~B nibble, first c_in = 1 (cmd_cin ignored). rsp_carry = 1 means no borrow.
  - INC: "+", in2 = 0, first c_in = 1.
  - DEC: "+", in2 = 4'hF, first c_in = 0.
  - AND/OR/XOR: "&"/"|"/"^". NOT: "~". For all four, c_in = 0, alu_c_out is ignored, and rsp_carry = 0.
  - RLC/RRC: first c_in = cmd_cin; rsp_carry = alu_c_out of the last slot.
- Carry chaining: alu_c_out sampled in slot k becomes alu_c_in of slot k+1.
- Leaving RUN: alu_op returns to 0.
- Latency: the accept cycle is cycle 0. rsp_valid rises in cycle WORDS*(ALU_LAT+1)+1, which is 9 at the defaults.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready; this is indefinite backpressure.
  - cmd_ready=0 throughout RUN and RESP.
  - On rsp_ready, return to IDLE; cmd_ready=1 in the next cycle.
  - A response and a command are never both transferred in the same cycle.

Decomposition:
- Package `alu_pkg` holds:
  - opcode localparams (OP_ADD .. OP_RRC);
  - the ASCII op constants ("+", "&", "|", "^", "~", "RLC", "RRC") as 25-bit values;
  - the NOP code 0;
  - the state encoding.
- No sub-module: the controller is a single FSM plus the slot and sub-cycle counters.
- The `ALU` is instantiated beside this block in the enclosing top, not inside it.

Test Plan:
- ADD A=16'h1234, B=16'h0FFF, cin=0 -> rsp_data 16'h2233, carry 0, zero 0; rsp_valid exactly 9 cycles after accept.
- ADD 16'hFFFF+16'h0001 -> 16'h0000, carry 1, zero 1. SUB 16'h1000-16'h0001 -> 16'h0FFF, carry 1. SUB 16'h0000-16'h0001 -> 16'hFFFF, carry 0.
- RLC A=16'h8001, cin=1 -> 16'h0003, carry 1. RRC A=16'h0001, cin=1 -> 16'h8000, carry 1; check the MSB-first alu_in1 sequence 0, 0, 0, 1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable and cmd_ready=0 throughout; accepted on the cycle rsp_ready rises.
- cmd_op=4'hC -> rsp_err=1, rsp_data=0 and rsp_valid in cycle 1; alu_op stays 0 throughout.
- Pull reset_n low in slot 2 of an ADD -> outputs clear immediately; no rsp_valid follows; the next ADD completes correctly with full latency.
